// File: rtl/nibble_ser_pkg.sv
// Shared types and helpers for the word-to-nibble serializer.
package nibble_ser_pkg;

    localparam int unsigned NIBBLE_SER_IN_W  = 32;
    localparam int unsigned NIBBLE_SER_OUT_W = 4;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } ser_state_e;

    // Nibbles per input word; a zero output width yields zero so that a bad
    // configuration is reported by the elaboration check, not a divide fault.
    function automatic int unsigned nibbles_per_word(input int unsigned in_w,
                                                     input int unsigned out_w);
        if (out_w == 0) begin
            return 0;
        end
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Word-to-nibble serializer: accepts one IN_W-bit word and emits it as
// IN_W/OUT_W consecutive OUT_W-bit nibbles over a valid/ready handshake.
// Build option: define NIBBLE_SER_MSB_FIRST_EN to emit the most significant
// nibble first; by default the least significant nibble leads, matching the
// truncating 32->4 path.
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int unsigned IN_W  = NIBBLE_SER_IN_W,
    parameter int unsigned OUT_W = NIBBLE_SER_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned NUM   = nibbles_per_word(IN_W, OUT_W);
    localparam int unsigned CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);

    if (IN_W == 0 || OUT_W == 0 || (IN_W % OUT_W) != 0) begin : g_param_check
        $error("nibble_serializer: IN_W must be a nonzero multiple of OUT_W");
    end

    ser_state_e       state_q;
    logic [IN_W-1:0]  shreg_q;
    logic [CNT_W-1:0] count_q;
    logic [OUT_W-1:0] data_q;
    logic             last_q;

    // Nibble presented first from a word, in the configured order.
    function automatic logic [OUT_W-1:0] head(input logic [IN_W-1:0] w);
`ifdef NIBBLE_SER_MSB_FIRST_EN
        return w[IN_W-1 -: OUT_W];
`else
        return w[OUT_W-1:0];
`endif
    endfunction

    // Word with its leading nibble consumed, next nibble moved into head position.
    function automatic logic [IN_W-1:0] tail(input logic [IN_W-1:0] w);
`ifdef NIBBLE_SER_MSB_FIRST_EN
        return w << OUT_W;
`else
        return w >> OUT_W;
`endif
    endfunction

    assign out_valid = (state_q == SHIFT);
    assign busy      = out_valid;
    assign out_data  = data_q;
    assign out_last  = last_q;

    // Accept a new word when idle, or on the final nibble's transfer so words chain bubble-free.
    assign in_ready = ~out_valid | (last_q & out_ready);

    // Serializer state: load on input transfer, step one nibble per output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= SHIFT;
                        data_q  <= head(in_data);
                        shreg_q <= tail(in_data);
                        count_q <= '0;
                        last_q  <= (NUM == 1);
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (last_q) begin
                            if (in_valid) begin
                                data_q  <= head(in_data);
                                shreg_q <= tail(in_data);
                                count_q <= '0;
                                last_q  <= (NUM == 1);
                            end else begin
                                // out_data keeps its stale value; it is don't-care while idle.
                                state_q <= IDLE;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            data_q  <= head(shreg_q);
                            shreg_q <= tail(shreg_q);
                            count_q <= count_q + CNT_W'(1);
                            last_q  <= ((count_q + CNT_W'(1)) == LAST_CNT);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed and randomized checks for nibble_serializer (32-bit words, 4-bit nibbles).
module tb_nibble_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;

    int n_vec;
    int n_miss;

    nibble_serializer #(
        .IN_W  (32),
        .OUT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

`ifdef NIBBLE_SER_MSB_FIRST_EN
    localparam int STALL_IDX = 5;
`else
    localparam int STALL_IDX = 2;
`endif

    // Bit position (in nibbles) of the k-th emitted nibble within its word.
    function automatic int nib_pos(input int k);
`ifdef NIBBLE_SER_MSB_FIRST_EN
        return 7 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [3:0] exp_nib(input logic [31:0] w, input int k);
        return w[nib_pos(k)*4 +: 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one word, drain it at full rate, confirm return to idle.
    task automatic serial_word(input string tag, input logic [31:0] w);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        #1;
        check({tag, "_accept_ready"}, in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out_data, exp_nib(w, k));
            check({tag, "_last"}, out_last, (k == 7));
        end
        @(negedge clk);
        #1;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] acc;
        int          k;
        int          sent;
        int          got;
        logic        hold;

        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat, only the lowest nibble set.
        serial_word("w08", 32'h0000_0008);

        // Ascending nibbles.
        serial_word("w1234", 32'h1234_5678);
        // Hand-computed first nibble of 12345678 in each build.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef NIBBLE_SER_MSB_FIRST_EN
        check("first_nib_const", out_data, 4'h1);
`else
        check("first_nib_const", out_data, 4'h8);
`endif

        // Backpressure: hold at the nibble of value 6 for 3 stalled cycles.
        for (int i = 1; i < STALL_IDX; i++) begin
            @(negedge clk);
            #1;
            check("bp_pre_data", out_data, exp_nib(32'h1234_5678, i));
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            out_ready = (s == 3);
            #1;
            check("bp_hold_data", out_data, 4'h6);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_last", out_last, 0);
            check("bp_in_ready", in_ready, 0);
        end
        for (int i = STALL_IDX + 1; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("bp_post_data", out_data, exp_nib(32'h1234_5678, i));
            check("bp_post_last", out_last, (i == 7));
        end
        @(negedge clk);
        #1;
        check("bp_idle", out_valid, 0);

        // Back-to-back words with no bubble.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_AAAA;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_valid = (c < 8);
            in_data  = 32'h5555_5555;
            #1;
            check("b2b_valid", out_valid, 1);
            check("b2b_data", out_data, (c < 8) ? 4'hA : 4'h5);
            check("b2b_last", out_last, (c % 8 == 7));
            check("b2b_in_ready", in_ready, (c % 8 == 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("b2b_idle", out_valid, 0);

        // Asynchronous reset in the middle of a word.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("mrst_data", out_data, exp_nib(32'hDEAD_BEEF, i));
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_last", out_last, 0);
        check("mrst_data0", out_data, 0);
        check("mrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_rel_valid", out_valid, 0);
        check("mrst_rel_ready", in_ready, 1);
        serial_word("w0f", 32'h0000_000F);

        // Randomized sweep with scoreboard reconstruction.
        sent = 0;
        got  = 0;
        k    = 0;
        hold = 1'b0;
        acc  = '0;
        for (int cyc = 0; cyc < 4000 && got < 30; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = (sent < 30) && ($urandom_range(0, 3) != 0);
                in_data  = $urandom();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                acc[nib_pos(k)*4 +: 4] = out_data;
                check("sweep_last", out_last, (k == 7));
                if (out_last) begin
                    check("sweep_q", q.size(), 1);
                    if (q.size() > 0) begin
                        check("sweep_word", acc, q.pop_front());
                    end
                    got++;
                    k = 0;
                end else begin
                    k++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("sweep_words", got, 30);
        check("sweep_sent", sent, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
